idu_id_nw: RTL

IDU_ID_NW -- requirements
Module: idu_id_nw

---
 rtl/idu_pkg.sv | 61 ++++++
 rtl/idu_id_dec.sv | 69 ++++++
 rtl/idu_id_nw.sv | 128 ++++++++++++
 3 files changed

// File: rtl/idu_pkg.sv
// Shared decode definitions: RV64I major opcodes, one-hot class and pipe
// encodings, immediate widths and the per-lane decode record.
package idu_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Instruction format, one-hot {R,I,S,B,U,J}; all-zero means unrecognised.
  localparam logic [5:0] TYPE_NONE = 6'b000000;
  localparam logic [5:0] TYPE_R    = 6'b100000;
  localparam logic [5:0] TYPE_I    = 6'b010000;
  localparam logic [5:0] TYPE_S    = 6'b001000;
  localparam logic [5:0] TYPE_B    = 6'b000100;
  localparam logic [5:0] TYPE_U    = 6'b000010;
  localparam logic [5:0] TYPE_J    = 6'b000001;

  // Issue pipe, one-hot {alu,mxu,bju,lsu,cp0}.
  localparam logic [4:0] PIPE_ALU = 5'b10000;
  localparam logic [4:0] PIPE_MXU = 5'b01000;
  localparam logic [4:0] PIPE_BJU = 5'b00100;
  localparam logic [4:0] PIPE_LSU = 5'b00010;
  localparam logic [4:0] PIPE_CP0 = 5'b00001;

  // Significant immediate bits before sign extension to 64.
  localparam int IMM_W_I = 12;
  localparam int IMM_W_S = 12;
  localparam int IMM_W_B = 13;
  localparam int IMM_W_J = 21;
  localparam int IMM_W_U = 32;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [9:0]  funct;    // {funct7,funct3}
    logic [1:0]  src_vld;  // {src2,src1}
    logic [9:0]  src;      // {rs2,rs1}
    logic        dst_vld;
    logic [4:0]  dst;
    logic        imm_vld;
    logic [63:0] imm;
    logic [5:0]  typ;
    logic [4:0]  pipe;
    logic        ras;
    logic        ill;
  } dec_t;

  // Lane-count helper; narrower masks are zero-extended by the caller.
  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/idu_id_dec.sv
// Single-lane combinational RV64I decoder producing one dec_t record.
module idu_id_dec
  import idu_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [5:0] typ;
  logic [4:0] pipe;
  logic       ras;
  logic       ill;

  // Classify the major opcode into format, pipe and return-address hint.
  always_comb begin
    typ  = TYPE_NONE;
    pipe = PIPE_CP0;
    ras  = 1'b0;
    ill  = 1'b0;
    case (inst_i[6:0])
      OPC_OP, OPC_OP32: begin
        typ  = TYPE_R;
        pipe = inst_i[25] ? PIPE_MXU : PIPE_ALU;  // funct7[0] selects M-extension
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin typ = TYPE_I; pipe = PIPE_ALU; end
      OPC_LUI:    begin typ = TYPE_U; pipe = PIPE_ALU; end
      OPC_AUIPC:  begin typ = TYPE_U; pipe = PIPE_BJU; end
      OPC_JAL:    begin typ = TYPE_J; pipe = PIPE_BJU; ras = 1'b1; end
      OPC_JALR:   begin typ = TYPE_I; pipe = PIPE_BJU; ras = 1'b1; end
      OPC_BRANCH: begin typ = TYPE_B; pipe = PIPE_BJU; end
      OPC_LOAD:   begin typ = TYPE_I; pipe = PIPE_LSU; end
      OPC_STORE:  begin typ = TYPE_S; pipe = PIPE_LSU; end
      OPC_SYSTEM: begin typ = TYPE_I; pipe = PIPE_CP0; end
      default:    ill = 1'b1;
    endcase
  end

  // Derive operand valids and the sign-extended immediate from the format.
  always_comb begin
    dec_o        = '0;
    dec_o.opcode = inst_i[6:0];
    dec_o.funct  = {inst_i[31:25], inst_i[14:12]};
    dec_o.src    = {inst_i[24:20], inst_i[19:15]};
    dec_o.dst    = inst_i[11:7];
    dec_o.typ    = typ;
    dec_o.pipe   = pipe;
    dec_o.ras    = ras;
    dec_o.ill    = ill;

    dec_o.src_vld[0] = (typ == TYPE_R) | (typ == TYPE_I) | (typ == TYPE_S) | (typ == TYPE_B);
    dec_o.src_vld[1] = (typ == TYPE_R) | (typ == TYPE_S) | (typ == TYPE_B);
    // Writes to x0 are discarded, so no physical register is needed.
    dec_o.dst_vld    = ((typ == TYPE_R) | (typ == TYPE_I) | (typ == TYPE_U) | (typ == TYPE_J))
                       & (inst_i[11:7] != 5'd0);
    dec_o.imm_vld    = (typ != TYPE_NONE) & (typ != TYPE_R);

    case (typ)
      TYPE_I: dec_o.imm = {{(64-IMM_W_I){inst_i[31]}}, inst_i[31:20]};
      TYPE_S: dec_o.imm = {{(64-IMM_W_S){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      TYPE_B: dec_o.imm = {{(64-IMM_W_B){inst_i[31]}}, inst_i[31], inst_i[7],
                           inst_i[30:25], inst_i[11:8], 1'b0};
      TYPE_J: dec_o.imm = {{(64-IMM_W_J){inst_i[31]}}, inst_i[31], inst_i[19:12],
                           inst_i[20], inst_i[30:21], 1'b0};
      TYPE_U: dec_o.imm = {{(64-IMM_W_U){inst_i[31]}}, inst_i[31:12], 12'b0};
      default: dec_o.imm = 64'd0;
    endcase
  end

endmodule

// File: rtl/idu_id_nw.sv
// N-wide decode stage: one output register slice with ready/valid handshake,
// global flush, request counts and a running handed-downstream counter.
module idu_id_nw
  import idu_pkg::*;
#(
  parameter int DW = 2,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic             clk,
  input  logic             rst_clk,
  input  logic             rtu_global_flush,
  input  logic [DW-1:0]    ifu_idu_id_vld,
  input  logic [DW*64-1:0] ifu_idu_id_pc,
  input  logic [DW*32-1:0] ifu_idu_id_inst,
  output logic             idu_ifu_id_rdy,
  input  logic             decode_rdy,
  output logic [DW-1:0]    decode_vld,
  output logic [DW*64-1:0] decode_pc,
  output logic [DW*7-1:0]  decode_opcode,
  output logic [DW*10-1:0] decode_funct,
  output logic [DW*2-1:0]  decode_src_vld,
  output logic [DW*10-1:0] decode_src,
  output logic [DW-1:0]    decode_dst_vld,
  output logic [DW*5-1:0]  decode_dst,
  output logic [DW-1:0]    decode_imm_vld,
  output logic [DW*64-1:0] decode_imm,
  output logic [DW*6-1:0]  decode_type,
  output logic [DW*5-1:0]  decode_pipe,
  output logic [DW-1:0]    decode_ras,
  output logic [DW-1:0]    decode_ill,
  output logic [CW-1:0]    iid_req_num,
  output logic [CW-1:0]    preg_req_num,
  output logic [63:0]      decode_cnt
);

  logic [DW-1:0] vld_q, vld_d;
  logic [63:0]   cnt_q, cnt_d;
  logic          in_xfer;
  logic          out_hs;

  assign idu_ifu_id_rdy = !rtu_global_flush & ((vld_q == '0) | decode_rdy);
  assign in_xfer        = (ifu_idu_id_vld != '0) & idu_ifu_id_rdy;
  assign out_hs         = (vld_q != '0) & decode_rdy;

  // Valid mask: flush clears, a transfer loads, a bare handshake empties.
  always_comb begin
    vld_d = vld_q;
    if (rtu_global_flush)  vld_d = '0;
    else if (in_xfer)      vld_d = ifu_idu_id_vld;
    else if (out_hs)       vld_d = '0;
  end

  // A handshake coinciding with a flush was already consumed downstream,
  // so it still counts; the flush itself never touches the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (out_hs) cnt_d = cnt_q + {61'd0, popcnt4(4'(vld_q))};
  end

  // Handshake state and counter registers.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_lane
      dec_t        dec_w;
      dec_t        lane_q, lane_d;
      logic [63:0] pc_q, pc_d;

      idu_id_dec u_dec (
        .inst_i (ifu_idu_id_inst[32*gi +: 32]),
        .dec_o  (dec_w)
      );

      // Lane payload: idle lanes of a loaded bundle are zeroed.
      always_comb begin
        lane_d = lane_q;
        pc_d   = pc_q;
        if (rtu_global_flush) begin
          lane_d = '0;
          pc_d   = '0;
        end else if (in_xfer) begin
          lane_d = ifu_idu_id_vld[gi] ? dec_w : '0;
          pc_d   = ifu_idu_id_vld[gi] ? ifu_idu_id_pc[64*gi +: 64] : 64'd0;
        end
      end

      // Lane payload registers.
      always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
          lane_q <= '0;
          pc_q   <= '0;
        end else begin
          lane_q <= lane_d;
          pc_q   <= pc_d;
        end
      end

      assign decode_pc[64*gi +: 64]      = pc_q;
      assign decode_opcode[7*gi +: 7]    = lane_q.opcode;
      assign decode_funct[10*gi +: 10]   = lane_q.funct;
      assign decode_src_vld[2*gi +: 2]   = lane_q.src_vld;
      assign decode_src[10*gi +: 10]     = lane_q.src;
      assign decode_dst_vld[gi]          = lane_q.dst_vld;
      assign decode_dst[5*gi +: 5]       = lane_q.dst;
      assign decode_imm_vld[gi]          = lane_q.imm_vld;
      assign decode_imm[64*gi +: 64]     = lane_q.imm;
      assign decode_type[6*gi +: 6]      = lane_q.typ;
      assign decode_pipe[5*gi +: 5]      = lane_q.pipe;
      assign decode_ras[gi]              = lane_q.ras;
      assign decode_ill[gi]              = lane_q.ill;
    end
  endgenerate

  assign decode_vld   = vld_q;
  assign decode_cnt   = cnt_q;
  assign iid_req_num  = CW'(popcnt4(4'(vld_q)));
  assign preg_req_num = CW'(popcnt4(4'(vld_q & decode_dst_vld)));

endmodule
